// File: rtl/instr_fetch_unit_pkg.sv
// Purpose : shared constants, fetch-entry type and PC helpers for the fetch path.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package instr_fetch_unit_pkg;

  localparam int ADDR_W      = 16;
  localparam int INSTR_W     = 16;
  localparam int MEM_BYTES   = 256;
  localparam int QUEUE_DEPTH = 2;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam logic [ADDR_W-1:0] PC_STEP  = 16'd2;

  // One bit wider than the address so the memory size itself is representable.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  // Entry handed from fetch to decode.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential PC, wrapping at the end of instruction memory.
  function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] pc);
    logic [ADDR_W:0] sum;
    sum = {1'b0, pc} + {1'b0, PC_STEP};
    if (sum >= MEM_LIMIT) sum = sum - MEM_LIMIT;
    return sum[ADDR_W-1:0];
  endfunction

  // A redirect target is unusable if it is odd or outside instruction memory.
  function automatic logic target_bad(input logic [ADDR_W-1:0] target);
    return target[0] || ({1'b0, target} >= MEM_LIMIT);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// Purpose : 2-entry synchronous FIFO between fetch and decode (module fetch_queue).
// Latency : push visible at dout on the next edge; simultaneous push+pop legal at any occupancy.
// Backpr. : caller must not push when full without popping; flush empties it in one edge.
// Ports   : clock, reset (async high), push, pop, flush, din -> dout (head entry), count (0..2).
module fetch_queue
  import instr_fetch_unit_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);

  fetch_entry_t entries [2];
  logic         head;
  logic         tail;
  logic         do_pop;
  logic         advance_head;

  assign do_pop = pop && (count != 2'd0);

  // head + count modulo 2; count==2 aliases back onto head, which is only
  // written when that same slot is being popped.
  assign tail = head ^ count[0];

  // Draining the last entry leaves head in place so dout keeps showing the
  // last delivered instruction while the queue is empty.
  assign advance_head = do_pop && !(count == 2'd1 && !push);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entries <= '{default: '0};
      head    <= 1'b0;
      count   <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (push) entries[tail] <= din;
      if (advance_head) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

  assign dout = entries[head];

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose : instruction fetch requester; owns the PC, reads imem, queues {pc,instr} for decode.
// Latency : fetch in cycle N, dec_valid on edge N (1 cycle); redirect target at decode 2 edges after redirect.
// Backpr. : fetch stalls when the 2-entry queue is full and not draining; halt/fault stop fetch, queue drains.
// Ports   : clock, reset (async high); imem_en/imem_addr/imem_data (memory, data combinational);
//           redirect_valid/redirect_pc; halt; dec_valid/dec_ready/dec_instr/dec_pc; fetch_fault (sticky).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic               fetch_fault
);

  logic [ADDR_W-1:0] pc;
  logic              fault_q;
  logic [1:0]        count;
  logic              handshake;
  logic              fetch;
  logic              redirect_take;
  fetch_entry_t      head;
  fetch_entry_t      new_entry;

  assign dec_valid = (count != 2'd0);
  assign handshake = dec_valid && dec_ready;

  // A slot is free if the queue is not full or its head leaves this cycle.
  assign fetch = !halt && !fault_q && !redirect_valid &&
                 ((count < 2'd2) || handshake);

  // Combinational fetch would otherwise be high while reset is held.
  assign imem_en   = fetch && !reset;
  assign imem_addr = pc;

  // Once faulted, further redirects are ignored until reset.
  assign redirect_take = redirect_valid && !fault_q;

  assign new_entry.pc    = pc;
  assign new_entry.instr = imem_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      fault_q <= 1'b0;
    end else if (redirect_take) begin
      // A bad target faults and leaves the PC where it was.
      if (target_bad(redirect_pc)) fault_q <= 1'b1;
      else                         pc      <= redirect_pc;
    end else if (fetch) begin
      pc <= pc_advance(pc);
    end
  end

  fetch_queue u_queue (
    .clock (clock),
    .reset (reset),
    .push  (fetch),
    .pop   (handshake),
    .flush (redirect_take),
    .din   (new_entry),
    .dout  (head),
    .count (count)
  );

  assign dec_instr   = head.instr;
  assign dec_pc      = head.pc;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : self-checking bench for instr_fetch_unit: queue-level reference model compared every
//           cycle, plus directed scenarios with hand-computed expectations.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  logic               fetch_fault;

  always #5 clock = ~clock;

  instr_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fetch_fault    (fetch_fault)
  );

  // Instruction memory: little-endian 16-bit words, combinational read.
  logic [7:0] mem [256];
  assign imem_data = {mem[imem_addr[7:0] + 8'd1], mem[imem_addr[7:0]]};

  function automatic logic [15:0] word_at(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return {mem[lo + 8'd1], mem[lo]};
  endfunction

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (queue of delivered instructions) ----------------
  logic [15:0]  mpc    = RESET_PC;
  bit           mfault = 1'b0;
  fetch_entry_t mq[$];
  fetch_entry_t mlast  = '0;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        mpc    = RESET_PC;
        mfault = 1'b0;
        mq.delete();
        mlast  = '0;
      end else begin
        bit pop;
        bit fet;
        pop = (mq.size() != 0) && dec_ready;
        fet = !halt && !mfault && !redirect_valid && ((mq.size() < 2) || pop);
        if (redirect_valid && !mfault) begin
          if (redirect_pc[0] || redirect_pc >= 16'd256) mfault = 1'b1;
          else mpc = redirect_pc;
          mq.delete();
        end else begin
          if (pop) void'(mq.pop_front());
          if (fet) begin
            mq.push_back('{pc: mpc, instr: word_at(mpc)});
            mpc = (mpc + 16'd2) % 16'd256;
          end
        end
        if (mq.size() != 0) mlast = mq[0];
      end
    end
  end

  // Every-cycle comparison on the falling edge, away from input changes.
  initial begin
    forever begin
      @(negedge clock);
      begin
        bit exp_en;
        exp_en = !reset && !halt && !mfault && !redirect_valid &&
                 ((mq.size() < 2) || ((mq.size() != 0) && dec_ready));
        chk("m_dec_valid",   dec_valid,   (mq.size() != 0));
        chk("m_dec_pc",      dec_pc,      mlast.pc);
        chk("m_dec_instr",   dec_instr,   mlast.instr);
        chk("m_fetch_fault", fetch_fault, mfault);
        chk("m_imem_en",     imem_en,     exp_en);
        chk("m_imem_addr",   imem_addr,   mpc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] exp_pc    [4];
  logic [15:0] exp_instr [4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
    exp_pc[0] = 16'h0000; exp_instr[0] = 16'h2211;
    exp_pc[1] = 16'h0002; exp_instr[1] = 16'h4433;
    exp_pc[2] = 16'h0004; exp_instr[2] = 16'h6655;
    exp_pc[3] = 16'h0006; exp_instr[3] = 16'h8877;

    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    repeat (2) step();
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_imem_en",   imem_en,   0);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    chk("rst_dec_pc",    dec_pc,    16'h0000);

    // Streaming with decode always ready.
    reset = 1'b0;
    #1;
    chk("t1_first_fetch_en", imem_en, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_dec_pc",    dec_pc,    exp_pc[i]);
      chk("t1_dec_instr", dec_instr, exp_instr[i]);
      chk("t1_imem_en",   imem_en,   1);
    end

    // Backpressure: decode stalled, queue fills with pc 0 and 2.
    dec_ready = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    step(); step();
    chk("t2_full_en",   imem_en,   0);
    chk("t2_full_addr", imem_addr, 16'h0004);
    chk("t2_full_head", dec_pc,    16'h0000);
    repeat (3) step();
    chk("t2_hold_addr", imem_addr, 16'h0004);
    dec_ready = 1'b1;
    #1;
    chk("t2_resume_en", imem_en, 1);
    step();
    chk("t2_pc2", dec_pc, 16'h0002);
    step();
    chk("t2_pc4", dec_pc, 16'h0004);

    // Redirect while queue holds pc 4 and 6.
    dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    #1;
    chk("t3_no_fetch", imem_en, 0);
    step();
    redirect_valid = 1'b0; dec_ready = 1'b1;
    chk("t3_flushed", dec_valid, 0);
    chk("t3_addr",    imem_addr, 16'h0040);
    step();
    chk("t3_valid", dec_valid, 1);
    chk("t3_pc40",  dec_pc,    16'h0040);
    step();
    chk("t3_pc42",  dec_pc,    16'h0042);

    // Misaligned redirect faults; later redirect ignored; reset clears.
    redirect_valid = 1'b1; redirect_pc = 16'h0041;
    step();
    redirect_valid = 1'b0;
    chk("t4_fault",     fetch_fault, 1);
    chk("t4_dec_valid", dec_valid,   0);
    chk("t4_en",        imem_en,     0);
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect_valid = 1'b0;
    step();
    chk("t4_still_fault", fetch_fault, 1);
    chk("t4_still_off",   imem_en,     0);
    chk("t4_pc_held",     imem_addr,   16'h0044);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t4_fault_clr", fetch_fault, 0);
    chk("t4_fetch_on",  imem_en,     1);

    // Halt: queue drains, pc holds, resume in same cycle.
    step(); step();
    chk("t5_pre_halt_pc", dec_pc, 16'h0002);
    halt = 1'b1;
    #1;
    chk("t5_halt_en", imem_en, 0);
    step();
    chk("t5_drained", dec_valid, 0);
    chk("t5_addr",    imem_addr, 16'h0004);
    step();
    halt = 1'b0;
    #1;
    chk("t5_resume_en",   imem_en,   1);
    chk("t5_resume_addr", imem_addr, 16'h0004);
    step();
    chk("t5_resume_pc", dec_pc, 16'h0004);

    // Wrap at the top of memory.
    redirect_valid = 1'b1; redirect_pc = 16'h00FC;
    step();
    redirect_valid = 1'b0;
    step(); chk("t6_fc", dec_pc, 16'h00FC);
    step(); chk("t6_fe", dec_pc, 16'h00FE);
    step(); chk("t6_00", dec_pc, 16'h0000);
    chk("t6_00_instr", dec_instr, 16'h2211);
    step(); chk("t6_02", dec_pc, 16'h0002);

    // Asynchronous reset mid-cycle with the queue full.
    dec_ready = 1'b0;
    repeat (3) step();
    chk("t7_full", imem_en, 0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("t7_async_valid", dec_valid,   0);
    chk("t7_async_pc",    dec_pc,      16'h0000);
    chk("t7_async_instr", dec_instr,   16'h0000);
    chk("t7_async_en",    imem_en,     0);
    chk("t7_async_fault", fetch_fault, 0);
    chk("t7_async_addr",  imem_addr,   16'h0000);
    step();
    reset = 1'b0; dec_ready = 1'b1;
    step();
    chk("t7_first_valid", dec_valid, 1);
    chk("t7_first_pc",    dec_pc,    16'h0000);
    chk("t7_first_instr", dec_instr, 16'h2211);
    step();
    chk("t7_second_pc",   dec_pc,    16'h0002);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Requester side of the instruction memory interface.
- Owns the program counter and drives the memory enable and byte address.
- Captures the 16-bit little-endian instruction the memory returns combinationally.
- Buffers fetched instructions in a 2-entry queue and hands them to decode with a valid/ready handshake, handling branch redirects and misaligned-target faults.

Parameters:
- ADDR_W, 16, width of PC and memory address bus
- INSTR_W, 16, instruction width (two bytes per instruction)
- MEM_BYTES, 256, instruction memory size in bytes; PC wraps modulo this value
- RESET_PC, 16'h0000, PC value loaded on reset
- QUEUE_DEPTH, 2, fetch queue entries (fixed at 2; other values unsupported)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- imem_en  output  1  memory read enable; high in every cycle a fetch is issued
- imem_addr  output  ADDR_W  byte address of instruction low byte (always even)
- imem_data  input  INSTR_W  instruction returned combinationally for imem_addr in the same cycle
- redirect_valid  input  1  branch/jump taken; flush and restart at redirect_pc
- redirect_pc  input  ADDR_W  redirect target byte address
- halt  input  1  suppress new fetches; queue still drains to decode
- dec_valid  output  1  queue head valid
- dec_ready  input  1  decode accepts head this cycle
- dec_instr  output  INSTR_W  instruction at queue head
- dec_pc  output  ADDR_W  byte address of dec_instr
- fetch_fault  output  1  sticky: redirect target odd or >= MEM_BYTES

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - pc = RESET_PC; queue emptied.
  - imem_en = 0, dec_valid = 0, dec_instr = 0, dec_pc = 0, fetch_fault = 0.
  - imem_addr = RESET_PC.
- Issue condition (combinational): fetch = !halt && !fetch_fault && !redirect_valid && (count < 2 || (dec_valid && dec_ready)).
  - imem_en = fetch.
  - imem_addr = pc always.
- On a clock edge with fetch = 1:
  - Enqueue {pc, imem_data}.
  - pc <= (pc + 2) mod MEM_BYTES; wraps 254 -> 0.
- Dequeue: dec_valid && dec_ready pops the head. Enqueue and dequeue in the same cycle are legal at any occupancy; count is unchanged.
- Queue outputs:
  - dec_valid = (count != 0).
  - dec_instr and dec_pc come from the head entry register.
  - When empty, dec_instr/dec_pc hold their last values.
- Latency:
  - The first fetch occurs in the first cycle after reset deasserts.
  - dec_valid rises on the following edge: 1-cycle fetch-to-decode latency.
- Redirect (redirect_valid = 1 at edge N):
  - A handshake in cycle N still counts as accepted.
  - Queue flushed (count <= 0); no fetch in cycle N.
  - pc <= redirect_pc.
  - Cycle N+1: fetch at target. Edge N+1: dec_valid = 1 with dec_pc = target.
- Redirect fault: redirect_pc[0] = 1 or redirect_pc >= MEM_BYTES.
  - fetch_fault <= 1, queue flushed, pc unchanged.
  - No further fetches until reset.
  - A later redirect_valid is ignored while faulted.
- Halt:
  - No enqueue; pc holds; queue drains normally.
  - Deasserting halt resumes fetch at the held pc in the same cycle.
- dec_ready while the queue is empty: no effect.
- Throughput: with dec_ready held high, one instruction per cycle, no bubbles.
- State: pc, 2 entries of {ADDR_W + INSTR_W} bits, head pointer (1 bit), count (2 bits), fault flag. No explicit FSM beyond RUN / HALTED / FAULT, derived from halt and fetch_fault.

Decomposition:
- Shared constants package:
  - INSTR_W, ADDR_W, MEM_BYTES, RESET_PC, PC_STEP = 2.
  - The fetch-entry struct {pc, instr}, also used by decode.
- One sub-module: fetch_queue, a 2-entry synchronous FIFO.
  - Inputs: push, pop, flush, din. Outputs: dout, count.
  - Asynchronous active-high reset.

Test Plan:
- Reset release, memory bytes 0..7 = 11,22,33,44,55,66,77,88, dec_ready = 1 -> dec_pc 0,2,4,6 on consecutive cycles; dec_instr 2211,4433,6655,8877 (hex); imem_en high every cycle.
- dec_ready = 0 for 5 cycles after reset -> queue fills with pc 0 and 2; imem_en drops once count = 2; imem_addr holds 4. Then dec_ready = 1 -> pcs 0,2,4 delivered with no gap and no duplicate.
- redirect_valid with redirect_pc = 16'h0040 while queue holds pc 4 and 6 -> both discarded; next dec_pc = 0x40 two edges later, then 0x42.
- redirect_pc = 16'h0041 -> fetch_fault = 1, dec_valid = 0 next cycle, imem_en stays 0. A later redirect to 0x10 is ignored. Reset clears the fault.
- redirect to 0xFC with dec_ready = 1 -> dec_pc sequence FC, FE, 00, 02 (wrap at MEM_BYTES).
- Assert reset asynchronously between edges with queue full -> outputs zero immediately. After release, dec_pc = RESET_PC first.
